// File: rtl/lap_timer_if.sv
// Bus bundle for the lap timer: button/control inputs and BCD display outputs.
// The master side drives the buttons and preset; the slave side is the timer.
interface lap_timer_if;
    logic        btn_start;
    logic        btn_lap;
    logic        down;
    logic        load;
    logic [15:0] preset;
    logic [15:0] digits;
    logic        running;
    logic        lap_hold;
    logic        expired;

    modport master (
        output btn_start, btn_lap, down, load, preset,
        input  digits, running, lap_hold, expired
    );

    modport slave (
        input  btn_start, btn_lap, down, load, preset,
        output digits, running, lap_hold, expired
    );
endinterface

// File: rtl/lap_timer.sv
// MM:SS stopwatch / countdown timer with debounced start and lap buttons,
// lap capture, BCD preset load and expiry pulse.
module lap_timer #(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned TICK_HZ   = 1,
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned WRAP      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    lap_timer_if.slave  bus
);

    localparam int unsigned Div  = CLK_HZ / TICK_HZ;
    localparam int unsigned PreW = (Div > 1) ? $clog2(Div) : 1;
    localparam int unsigned DbW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    // Bit 0 carries the start button, bit 1 the lap button.
    logic [1:0]          sync1_q, sync2_q;
    logic [1:0]          level_q, level_d;
    logic [1:0]          press_q, press_d;
    logic [1:0][DbW-1:0] db_cnt_q, db_cnt_d;

    logic [PreW-1:0] pre_q, pre_d;
    logic [15:0]     count_q, count_d;
    logic [15:0]     lap_q, lap_d;
    logic            hold_q, hold_d;
    logic            running_q, running_d;
    logic            expired_q, expired_d;

    logic            tick;
    logic            start_ev, lap_ev;
    logic [15:0]     inc_val, dec_val, clamp_val;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd5) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (v[11:8] != 4'd9) begin
                    r[11:8] = v[11:8] + 4'd1;
                end else begin
                    r[11:8]  = 4'd0;
                    r[15:12] = (v[15:12] != 4'd5) ? v[15:12] + 4'd1 : 4'd0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (v[7:4] != 4'd0) begin
                r[7:4] = v[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (v[11:8] != 4'd0) begin
                    r[11:8] = v[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = (v[15:12] != 4'd0) ? v[15:12] - 4'd1 : 4'd5;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
        logic [15:0] r;
        r[15:12] = (v[15:12] > 4'd5) ? 4'd5 : v[15:12];
        r[11:8]  = (v[11:8]  > 4'd9) ? 4'd9 : v[11:8];
        r[7:4]   = (v[7:4]   > 4'd5) ? 4'd5 : v[7:4];
        r[3:0]   = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
        return r;
    endfunction

    assign inc_val   = bcd_inc(count_q);
    assign dec_val   = bcd_dec(count_q);
    assign clamp_val = bcd_clamp(bus.preset);

    // Level flips only after DB_CYCLES consecutive samples disagreeing with it.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DbW'(DB_CYCLES - 1)) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
        press_d = level_d & ~level_q;
    end

    assign start_ev = press_q[0];
    assign lap_ev   = press_q[1];
    assign tick     = running_q && (pre_q == PreW'(Div - 1));

    always_comb begin
        pre_d     = (!running_q || bus.load || tick) ? '0 : pre_q + 1'b1;
        count_d   = count_q;
        lap_d     = lap_q;
        hold_d    = hold_q;
        running_d = running_q ^ start_ev;
        expired_d = 1'b0;

        if (bus.load) begin
            count_d = clamp_val;
            hold_d  = 1'b0;
        end else begin
            // Lap is judged against the running value before any start toggle.
            if (lap_ev) begin
                if (running_q) begin
                    hold_d = ~hold_q;
                    if (!hold_q) begin
                        lap_d = count_q;
                    end
                end else if (hold_q) begin
                    hold_d = 1'b0;
                end else begin
                    count_d = '0;
                end
            end
            if (tick) begin
                if (bus.down) begin
                    if (count_q != 16'h0000) begin
                        count_d = dec_val;
                    end
                    if (count_q == 16'h0000 || dec_val == 16'h0000) begin
                        expired_d = 1'b1;
                        running_d = 1'b0;
                    end
                end else if (count_q == 16'h5959) begin
                    if (WRAP != 0) begin
                        count_d = '0;
                    end else begin
                        running_d = 1'b0;
                    end
                end else begin
                    count_d = inc_val;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            db_cnt_q  <= '0;
            pre_q     <= '0;
            count_q   <= '0;
            lap_q     <= '0;
            hold_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            sync1_q   <= {bus.btn_lap, bus.btn_start};
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            db_cnt_q  <= db_cnt_d;
            pre_q     <= pre_d;
            count_q   <= count_d;
            lap_q     <= lap_d;
            hold_q    <= hold_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

    assign bus.digits   = hold_q ? lap_q : count_q;
    assign bus.running  = running_q;
    assign bus.lap_hold = hold_q;
    assign bus.expired  = expired_q;

endmodule
